// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the decoded key event bundle seen by the downstream square handler.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output row, input col, key_code, key_valid, key_held);
    modport slave  (input row, output col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with sweep-level debounce and a single strobe per press.
// Define TYPEMATIC_EN to add auto-repeat strobes every REPEAT_SWEEPS sweeps while held.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SWEEPS  = 200
) (
    input  logic            clk,
    input  logic            RST_BTN,
    keypad_scanner_if.slave kp
);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {SCAN, EVAL} state_e;

    state_e      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0] hit_q, hit_d;
    // Candidates are {is_key, code}; all-zero means no key, so reset clears to NONE.
    logic [4:0]  prev_q, prev_d;
    logic [4:0]  acc_q, acc_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic [4:0]  cand;
    logic        accept, release_ev, same;
`ifdef TYPEMATIC_EN
    localparam int RW = $clog2(REPEAT_SWEEPS + 1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;  default: key_map = 4'hD;
        endcase
    endfunction

    // Hit index is col*4+row, so scanning downward leaves the lowest column/row winner.
    always_comb begin
        cand = 5'b0;
        for (int i = 15; i >= 0; i--)
            if (hit_q[i]) cand = {1'b1, key_map(4'(i))};
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tick_d     = tick_q;
        hit_d      = hit_q;
        prev_d     = prev_q;
        acc_d      = acc_q;
        stable_d   = stable_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        accept     = 1'b0;
        release_ev = 1'b0;
        same       = (cand == prev_q);
        kp.col     = 4'b1111;
`ifdef TYPEMATIC_EN
        rpt_d      = rpt_q;
`endif
        case (state_q)
            SCAN: begin
                kp.col = ~(4'b0001 << k_q);
                if (tick_q == TW'(SCAN_TICKS - 1)) begin
                    hit_d[{k_q, 2'b00} +: 4] = ~kp.row;
                    tick_d = '0;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) state_d = EVAL;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                if (same) begin
                    if (stable_q != SW'(DEBOUNCE_SCANS)) stable_d = stable_q + 1'b1;
                end else begin
                    stable_d = SW'(1);
                    prev_d   = cand;
                end
                if (stable_d == SW'(DEBOUNCE_SCANS)) begin
                    if (cand[4] && cand != acc_q) begin
                        accept  = 1'b1;
                        acc_d   = cand;
                        code_d  = cand[3:0];
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end else if (!cand[4] && acc_q[4]) begin
                        release_ev = 1'b1;
                        acc_d      = 5'b0;
                        held_d     = 1'b0;
                    end
                end
`ifdef TYPEMATIC_EN
                if (accept || release_ev) begin
                    rpt_d = '0;
                end else if (held_q && same && cand == acc_q) begin
                    if (rpt_q == RW'(REPEAT_SWEEPS - 1)) begin
                        rpt_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end else begin
                    rpt_d = '0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST_BTN) begin
            state_q  <= SCAN;
            k_q      <= '0;
            tick_q   <= '0;
            hit_q    <= '0;
            prev_q   <= '0;
            acc_q    <= '0;
            stable_q <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
`ifdef TYPEMATIC_EN
            rpt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            tick_q   <= tick_d;
            hit_q    <= hit_d;
            prev_q   <= prev_d;
            acc_q    <= acc_d;
            stable_q <= stable_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
`ifdef TYPEMATIC_EN
            rpt_q    <= rpt_d;
`endif
        end
    end

    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed table, hand-written reset/repeat sequences, and random
// key traffic compared every cycle against a sweep-level behavioural model.
module tb_keypad_scanner;
    localparam int ST = 4, DB = 2, RS = 3, SWP = 4 * ST + 1;

    logic        clk = 1'b0;
    logic        RST_BTN;
    logic [15:0] keys;   // bit c*4+r = key at column c, row r physically pressed
    int          errors = 0, checks = 0, nprint = 0;

    keypad_scanner_if kif();
    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB), .REPEAT_SWEEPS(RS))
        dut (.clk(clk), .RST_BTN(RST_BTN), .kp(kif));

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kif.row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col[c] && keys[c*4+r]) kif.row[r] = 1'b0;
    end

    function automatic int code_of(input int idx);
        case (idx)
            0: return 1;   1: return 4;   2: return 7;   3: return 0;
            4: return 2;   5: return 5;   6: return 8;   7: return 15;
            8: return 3;   9: return 6;   10: return 9;  11: return 14;
            12: return 10; 13: return 11; 14: return 12; default: return 13;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (nprint < 30) begin
                nprint++;
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            end
        end
    endtask

    // Reference model: one step per clock, state advanced at the negedge from posedge snapshots.
    logic [15:0] s_keys;
    logic        s_rst;
    initial forever begin
        @(posedge clk);
        s_keys = keys;
        s_rst  = RST_BTN;
    end

    int          m_pos, m_acc, m_prev, m_rpt;
    int          m_hist[$];
    logic [15:0] m_hits;
    logic [3:0]  m_code;
    logic        m_valid, m_held, m_live = 1'b0, prev_valid = 1'b0;

    task automatic model_step();
        int  cand;
        bit  stable, ev;
        m_valid = 1'b0;
        if (m_pos < 16 && m_pos % 4 == 3)
            for (int r = 0; r < 4; r++) m_hits[(m_pos/4)*4+r] = s_keys[(m_pos/4)*4+r];
        if (m_pos == 16) begin
            cand = -1;
            for (int i = 15; i >= 0; i--) if (m_hits[i]) cand = code_of(i);
            m_hist.push_back(cand);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            stable = (m_hist.size() == DB);
            foreach (m_hist[j]) if (m_hist[j] != cand) stable = 0;
            ev = 0;
            if (stable && cand >= 0 && cand != m_acc) begin
                m_code = cand[3:0]; m_valid = 1'b1; m_held = 1'b1; m_acc = cand; ev = 1;
            end else if (stable && cand < 0 && m_acc >= 0) begin
                m_held = 1'b0; m_acc = -1; ev = 1;
            end
`ifdef TYPEMATIC_EN
            if (ev) m_rpt = 0;
            else if (m_held && cand == m_prev && cand == m_acc) begin
                m_rpt++;
                if (m_rpt == RS) begin m_rpt = 0; m_valid = 1'b1; end
            end else m_rpt = 0;
`endif
            m_prev = cand;
        end
        m_pos = (m_pos == 16) ? 0 : m_pos + 1;
    endtask

    initial forever begin
        logic [3:0] ecol;
        @(negedge clk);
        if (s_rst === 1'b1) begin
            m_pos = 0; m_hist.delete(); m_acc = -1; m_prev = -1; m_rpt = 0;
            m_hits = '0; m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            model_step();
        end
        if (m_live) begin
            ecol = (m_pos < 16) ? ~(4'b0001 << (m_pos / 4)) : 4'hF;
            chk("cycle{col,code,valid,held}",
                {22'd0, kif.col, kif.key_code, kif.key_valid, kif.key_held},
                {22'd0, ecol, m_code, m_valid, m_held});
            if (kif.key_valid) chk("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
        end
        prev_valid = kif.key_valid;
    end

    typedef struct {
        logic [15:0] keys;
        int          sweeps;
        logic [3:0]  code;
        logic        held;
        int          strobes;
    } vec_t;

    task automatic run_sweeps(input int n, output int strobes);
        strobes = 0;
        repeat (n * SWP) begin
            @(negedge clk);
            if (kif.key_valid) strobes++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_col"},   {28'd0, kif.col},      32'hE);
        chk({tag, "_code"},  {28'd0, kif.key_code}, 32'h0);
        chk({tag, "_valid"}, {31'd0, kif.key_valid}, 32'd0);
        chk({tag, "_held"},  {31'd0, kif.key_held},  32'd0);
    endtask

    initial begin
        vec_t tv[16];
        int   st, n, exp_rep;
        tv[0]  = '{16'h0000, 6, 4'h0, 1'b0, 0};  // idle
        tv[1]  = '{16'h0020, 2, 4'h5, 1'b1, 1};  // hold 5
        tv[2]  = '{16'h0000, 2, 4'h5, 1'b0, 0};  // release
        tv[3]  = '{16'h0020, 1, 4'h5, 1'b0, 0};  // bounce
        tv[4]  = '{16'h0000, 1, 4'h5, 1'b0, 0};
        tv[5]  = '{16'h0020, 1, 4'h5, 1'b0, 0};
        tv[6]  = '{16'h0000, 1, 4'h5, 1'b0, 0};
        tv[7]  = '{16'h0020, 1, 4'h5, 1'b0, 0};
        tv[8]  = '{16'h0000, 1, 4'h5, 1'b0, 0};
        tv[9]  = '{16'h0020, 2, 4'h5, 1'b1, 1};  // stable pair
        tv[10] = '{16'h0000, 2, 4'h5, 1'b0, 0};
        tv[11] = '{16'h8001, 2, 4'h1, 1'b1, 1};  // 1 and D: priority to 1
        tv[12] = '{16'h8000, 2, 4'hD, 1'b1, 1};  // drop 1, D takes over
        tv[13] = '{16'h0000, 2, 4'hD, 1'b0, 0};
        tv[14] = '{16'h0006, 2, 4'h4, 1'b1, 1};  // 4 and 7 same column: row priority
        tv[15] = '{16'h0000, 2, 4'h4, 1'b0, 0};

        keys = '0;
        RST_BTN = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        RST_BTN = 1'b0;

        for (int i = 0; i < 16; i++) begin
            keys = tv[i].keys;
            run_sweeps(tv[i].sweeps, st);
            chk($sformatf("vec%0d_strobes", i), st, tv[i].strobes);
            chk($sformatf("vec%0d_code", i), {28'd0, kif.key_code}, {28'd0, tv[i].code});
            chk($sformatf("vec%0d_held", i), {31'd0, kif.key_held}, {31'd0, tv[i].held});
        end

        // Key 9 stable for one sweep, then reset mid-sweep: history must restart.
        keys = 16'h0400;
        repeat (SWP + 6) @(negedge clk);
        RST_BTN = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        RST_BTN = 1'b0;
        n = 0;
        while (!kif.key_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_strobe_cycle", n, 2 * SWP);
        chk("midreset_code", {28'd0, kif.key_code}, 32'h9);

        // Long hold of A: repeat strobes only in the typematic build.
        keys = '0;
        run_sweeps(2, st);
        chk("pre_a_held", {31'd0, kif.key_held}, 32'd0);
        keys = 16'h1000;
        run_sweeps(12, st);
`ifdef TYPEMATIC_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        chk("hold_a_strobes", st, exp_rep);
        chk("hold_a_code", {28'd0, kif.key_code}, 32'hA);

        // Random traffic, including mid-sweep key changes and occasional resets.
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0: keys = '0;
                1: keys = 16'h0001 << $urandom_range(0, 15);
                2: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) begin
                RST_BTN = 1'b1;
                @(negedge clk);
                RST_BTN = 1'b0;
            end
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
